// File: rtl/iq_tone_gen.sv
// I/Q test-tone source: phase accumulator driving a full-wave cosine ROM, amplitude scaling,
// and a valid/ready sample stream; programmed through the enabel/address/data register bus.
module iq_tone_gen #(
    parameter int CLK_REF    = 50_000_000,
    parameter int SAMPL_T    = 1_000_000,
    parameter int FRQ_SIGNAL = 440_000,
    parameter int PHASE_W    = 32,
    parameter int LUT_AW     = 8,
    parameter int DATA_W     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enabel,
    input  logic [2:0]  address,
    input  logic [31:0] data,
    input  logic        ready,
    output logic [31:0] i,
    output logic [31:0] q,
    output logic        valid,
    output logic        overrun
);
    localparam int T      = CLK_REF / SAMPL_T;
    localparam int CNT_W  = $clog2(T);
    localparam int LUT_N  = 1 << LUT_AW;
    localparam int P      = (1 << (DATA_W - 1)) - 1;
    localparam int PROD_W = DATA_W + 18;
    localparam longint FTW_RST_L =
        ((longint'(FRQ_SIGNAL) << PHASE_W) + longint'(SAMPL_T) / 2) / longint'(SAMPL_T);
    localparam logic [PHASE_W-1:0] FTW_RST = PHASE_W'(FTW_RST_L);
    localparam logic [PHASE_W-1:0] QUARTER = {2'b01, {(PHASE_W - 2){1'b0}}};
    localparam logic signed [PROD_W-1:0] P_HI = PROD_W'(P);
    localparam logic signed [PROD_W-1:0] P_LO = -P_HI;
    localparam logic signed [PROD_W-1:0] RND  = PROD_W'(1 << 14);
    localparam logic [16:0] AMP_MAX = 17'd32768;

    // Elaboration-time only: each ROM word is a constant, round half away from zero.
    function automatic logic signed [DATA_W-1:0] cos_entry(input int k);
        real x;
        x = $itor(P) * $cos(2.0 * 3.14159265358979323846 * $itor(k) / $itor(LUT_N));
        if (x >= 0.0) return DATA_W'($rtoi(x + 0.5));
        else          return -DATA_W'($rtoi(0.5 - x));
    endfunction

    function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [PROD_W-1:0] p);
        logic signed [PROD_W-1:0] r;
        r = (p + RND) >>> 15;
        if (r > P_HI)      return P_HI[DATA_W-1:0];
        else if (r < P_LO) return P_LO[DATA_W-1:0];
        else               return $signed(r[DATA_W-1:0]);
    endfunction

    logic signed [DATA_W-1:0] rom [LUT_N];
    for (genvar k = 0; k < LUT_N; k++) begin : g_rom
        localparam logic signed [DATA_W-1:0] ENTRY = cos_entry(k);
        assign rom[k] = ENTRY;
    end

    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [PHASE_W-1:0]        ftw_sh_q, ftw_sh_d, pofs_sh_q, pofs_sh_d;
    logic [16:0]               amp_sh_q, amp_sh_d, amp_q, amp_d;
    logic                      run_sh_q, run_sh_d;
    logic [PHASE_W-1:0]        phase_q, phase_d;
    logic [PHASE_W-1:0]        s1_ph_q, s1_ph_d;
    logic                      s1_v_q, s1_v_d, s2_v_q, s2_v_d, s3_v_q, s3_v_d;
    logic signed [DATA_W-1:0]  s2_ri_q, s2_ri_d, s2_rq_q, s2_rq_d;
    logic signed [PROD_W-1:0]  s3_pi_q, s3_pi_d, s3_pq_q, s3_pq_d;
    logic [31:0]               i_q, i_d, q_q, q_d;
    logic                      valid_q, valid_d, overrun_q, overrun_d;
    logic                      strobe;
    logic [PHASE_W-1:0]        ph_q90;

    assign strobe = (cnt_q == CNT_W'(T - 1));

    always_comb begin
        cnt_d     = strobe ? '0 : cnt_q + 1'b1;
        ftw_sh_d  = ftw_sh_q;
        pofs_sh_d = pofs_sh_q;
        amp_sh_d  = amp_sh_q;
        run_sh_d  = run_sh_q;
        amp_d     = amp_q;
        phase_d   = phase_q;
        s1_ph_d   = s1_ph_q;
        s1_v_d    = 1'b0;
        if (enabel) begin
            case (address)
                3'd0: ftw_sh_d  = data[PHASE_W-1:0];
                3'd1: amp_sh_d  = (data[16:0] > AMP_MAX) ? AMP_MAX : data[16:0];
                3'd2: pofs_sh_d = data[PHASE_W-1:0];
                3'd3: run_sh_d  = data[0];
                default: ;
            endcase
        end
        // Shadow values are consumed directly at the strobe, so a write in that same clock waits one interval.
        if (strobe) begin
            amp_d = amp_sh_q;
            if (run_sh_q) begin
                s1_ph_d = phase_q + pofs_sh_q;
                s1_v_d  = 1'b1;
                phase_d = phase_q + ftw_sh_q;
            end
        end
    end

    always_comb begin
        ph_q90  = s1_ph_q - QUARTER;
        s2_ri_d = rom[s1_ph_q[PHASE_W-1 -: LUT_AW]];
        s2_rq_d = rom[ph_q90[PHASE_W-1 -: LUT_AW]];
        s2_v_d  = s1_v_q;
        s3_pi_d = PROD_W'(s2_ri_q) * PROD_W'($signed({1'b0, amp_q}));
        s3_pq_d = PROD_W'(s2_rq_q) * PROD_W'($signed({1'b0, amp_q}));
        s3_v_d  = s2_v_q;
    end

    // Output stage: a held, unaccepted sample wins over a newly arriving one.
    always_comb begin
        i_d       = i_q;
        q_d       = q_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (valid_q && ready) valid_d = 1'b0;
        if (enabel && address == 3'd3 && data[1]) overrun_d = 1'b0;
        if (s3_v_q) begin
            if (valid_q && !ready) begin
                overrun_d = 1'b1;
            end else begin
                i_d     = 32'(round_sat(s3_pi_q));
                q_d     = 32'(round_sat(s3_pq_q));
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            ftw_sh_q  <= FTW_RST;
            pofs_sh_q <= '0;
            amp_sh_q  <= AMP_MAX;
            amp_q     <= AMP_MAX;
            run_sh_q  <= 1'b1;
            phase_q   <= '0;
            s1_ph_q   <= '0;
            s1_v_q    <= 1'b0;
            s2_ri_q   <= '0;
            s2_rq_q   <= '0;
            s2_v_q    <= 1'b0;
            s3_pi_q   <= '0;
            s3_pq_q   <= '0;
            s3_v_q    <= 1'b0;
            i_q       <= '0;
            q_q       <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            ftw_sh_q  <= ftw_sh_d;
            pofs_sh_q <= pofs_sh_d;
            amp_sh_q  <= amp_sh_d;
            amp_q     <= amp_d;
            run_sh_q  <= run_sh_d;
            phase_q   <= phase_d;
            s1_ph_q   <= s1_ph_d;
            s1_v_q    <= s1_v_d;
            s2_ri_q   <= s2_ri_d;
            s2_rq_q   <= s2_rq_d;
            s2_v_q    <= s2_v_d;
            s3_pi_q   <= s3_pi_d;
            s3_pq_q   <= s3_pq_d;
            s3_v_q    <= s3_v_d;
            i_q       <= i_d;
            q_q       <= q_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign i       = i_q;
    assign q       = q_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;
endmodule

// File: tb/tb_iq_tone_gen.sv
// Directed bench for iq_tone_gen: register programming, tone sequence, amplitude,
// phase offset, backpressure/overrun, RUN gating and mid-sample reset.
module tb_iq_tone_gen;
    localparam int T = 50;

    logic        clk = 1'b0;
    logic        reset, enabel, ready;
    logic [2:0]  address;
    logic [31:0] data, i, q;
    logic        valid, overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int c0 = 0;
    int vcyc = 0;
    int seen = 0;
    int ti[5] = '{32767, 0, -32767, 0, 32767};
    int tq[5] = '{0, 32767, 0, -32767, 0};

    iq_tone_gen dut (
        .clk(clk), .reset(reset), .enabel(enabel), .address(address), .data(data),
        .ready(ready), .i(i), .q(q), .valid(valid), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        enabel = 1'b1; address = a; data = d;
        @(posedge clk);
        #1;
        enabel = 1'b0;
    endtask

    // Waits (bounded) for the next valid pulse and checks strobe alignment and sample values.
    task automatic wait_sample(input string tag, input int ei, input int eq);
        int n = 0;
        do begin
            tick(1);
            n++;
        end while (valid !== 1'b1 && n < 60);
        vcyc = cyc - c0;
        chk({tag, " valid"}, 32'(valid), 32'd1);
        chk({tag, " slot"}, 32'(vcyc % T), 32'd3);
        chk({tag, " i"}, i, 32'(ei));
        chk({tag, " q"}, q, 32'(eq));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enabel = 1'b0; address = 3'd0; data = 32'd0; ready = 1'b1;
        tick(3);
        c0 = cyc;
        reset = 1'b0;
        chk("rst valid", 32'(valid), 32'd0);
        chk("rst overrun", 32'(overrun), 32'd0);
        chk("rst i", i, 32'd0);
        chk("rst q", q, 32'd0);

        wr(3'd0, 32'd0);
        wait_sample("dc1", 32767, 0);
        chk("dc1 latency", 32'(vcyc), 32'd53);
        wait_sample("dc2", 32767, 0);
        chk("dc2 latency", 32'(vcyc), 32'd103);

        wr(3'd1, 32'd16384);
        wait_sample("amp half", 16384, 0);
        wr(3'd1, 32'h0001_FFFF);
        wait_sample("amp clamp", 32767, 0);
        wr(3'd1, 32'd0);
        wait_sample("amp zero", 0, 0);
        wr(3'd1, 32'd32768);
        wr(3'd2, 32'h8000_0000);
        wait_sample("pofs 180", -32767, 0);
        wr(3'd2, 32'd0);
        wait_sample("pofs 0", 32767, 0);

        while ((cyc - c0) % T != 9) tick(1);
        wr(3'd0, 32'h4000_0000);
        for (int k = 0; k < 5; k++) wait_sample($sformatf("tone%0d", k), ti[k], tq[k]);

        // Hold off the sink: the 90 degree sample must stay, 180 and 270 get dropped.
        tick(1);
        ready = 1'b0;
        wait_sample("bp first", 0, 32767);
        chk("bp first overrun", 32'(overrun), 32'd0);
        for (int k = 1; k <= 101; k++) begin
            tick(1);
            chk("bp hold valid", 32'(valid), 32'd1);
            chk("bp hold i", i, 32'd0);
            chk("bp hold q", q, 32'd32767);
            if (k == 49) chk("bp overrun before drop", 32'(overrun), 32'd0);
            if (k == 50) chk("bp overrun after drop", 32'(overrun), 32'd1);
        end
        ready = 1'b1;
        tick(1);
        chk("bp accepted valid", 32'(valid), 32'd0);
        chk("bp sticky overrun", 32'(overrun), 32'd1);
        wr(3'd3, 32'd3);
        chk("overrun cleared", 32'(overrun), 32'd0);
        wait_sample("after bp", 32767, 0);

        wr(3'd3, 32'd0);
        seen = 0;
        for (int k = 0; k < 110; k++) begin
            tick(1);
            if (valid === 1'b1) seen++;
        end
        chk("run0 no samples", 32'(seen), 32'd0);
        wr(3'd3, 32'd1);
        wait_sample("run resume", 0, 32767);

        // Reset while the next (180 degree) sample sits in the multiply stage.
        while ((cyc - c0) % T != 2) tick(1);
        reset = 1'b1;
        tick(1);
        c0 = cyc;
        reset = 1'b0;
        chk("mid rst valid", 32'(valid), 32'd0);
        chk("mid rst i", i, 32'd0);
        chk("mid rst q", q, 32'd0);
        chk("mid rst overrun", 32'(overrun), 32'd0);
        tick(5);
        chk("mid rst flushed", 32'(valid), 32'd0);
        wr(3'd0, 32'd0);
        wait_sample("post rst", 32767, 0);
        chk("post rst latency", 32'(vcyc), 32'd53);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
